mcu_spi_target: RTL and testbench

- Byte-level SPI target (slave) between the board MCU and the core-side control blocks (system control, HID, OSD, SD).
- Oversamples the MCU SPI pins on the core clock and assembles MSB-first bytes.
- Routes each frame's bytes to one of NTARGET consumers as a strobe/start/data stream.
- Shifts the selected consumer's reply byte back to the MCU on MISO.

---
 rtl/mcu_spi_target.sv | 157 +++++++++++++++
 tb/tb_mcu_spi_target.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_spi_target.sv
// Byte-level SPI mode-0 target: oversamples the MCU pins on clk, routes each
// frame's bytes to one of NTARGET consumers and returns their replies on MISO.
module mcu_spi_target #(
   parameter int NTARGET     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   spi_ss_n,
   input  logic                   spi_sclk,
   input  logic                   spi_mosi,
   output logic                   spi_miso,
   output logic [NTARGET-1:0]     data_strobe,
   output logic                   data_start,
   output logic [7:0]             data_out,
   input  logic [8*NTARGET-1:0]   data_in
);

   localparam int TW = (NTARGET > 1) ? $clog2(NTARGET) : 1;

   typedef enum logic [1:0] {
      PH_ID   = 2'd0,
      PH_CMD  = 2'd1,
      PH_DATA = 2'd2
   } phase_t;

   logic [SYNC_STAGES-1:0] r_ss_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES:0]   r_sync_vld;
   logic                   r_ss_prev;
   logic                   r_sclk_prev;
   logic                   r_active;
   logic [2:0]             r_bit_cnt;
   logic [6:0]             r_shift;
   phase_t                 r_phase;
   phase_t                 w_phase_nxt;
   logic                   r_tgt_vld;
   logic [TW-1:0]          r_tgt;
   logic [NTARGET-1:0]     r_strobe;
   logic                   r_start;
   logic [7:0]             r_data;
   logic                   r_load;
   logic [7:0]             r_miso_sr;

   logic       w_ss;
   logic       w_sclk;
   logic       w_mosi;
   logic       w_ss_fall;
   logic       w_sclk_rise;
   logic       w_sclk_fall;
   logic       w_live;
   logic       w_bit_rx;
   logic       w_byte_done;
   logic [7:0] w_byte;
   logic       w_id_ok;

   assign w_ss   = r_ss_sync[SYNC_STAGES-1];
   assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // A falling edge only counts once the chain holds real samples, so a chip
   // select already low when reset releases does not open a frame.
   assign w_ss_fall   = r_sync_vld[SYNC_STAGES] & r_ss_prev & ~w_ss;
   assign w_sclk_rise = w_sclk & ~r_sclk_prev;
   assign w_sclk_fall = ~w_sclk & r_sclk_prev;
   assign w_live      = r_active & ~w_ss;
   assign w_bit_rx    = w_live & w_sclk_rise;
   assign w_byte_done = w_bit_rx & (r_bit_cnt == 3'd7);
   assign w_byte      = {r_shift, w_mosi};
   assign w_id_ok     = (w_byte != 8'd0) && (w_byte <= 8'(NTARGET));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_phase <= PH_ID;
      else       r_phase <= w_phase_nxt;
   end

   always_comb begin
      w_phase_nxt = r_phase;
      if (w_ss || w_ss_fall) begin
         w_phase_nxt = PH_ID;
      end else if (w_byte_done) begin
         case (r_phase)
            PH_ID:   w_phase_nxt = PH_CMD;
            default: w_phase_nxt = PH_DATA;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ss_sync   <= '1;
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_sync_vld  <= '0;
         r_ss_prev   <= 1'b1;
         r_sclk_prev <= 1'b0;
         r_active    <= 1'b0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 7'd0;
         r_tgt_vld   <= 1'b0;
         r_tgt       <= '0;
         r_strobe    <= '0;
         r_start     <= 1'b0;
         r_data      <= 8'd0;
         r_load      <= 1'b0;
         r_miso_sr   <= 8'd0;
      end else begin
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_sync_vld  <= {r_sync_vld[SYNC_STAGES-1:0], 1'b1};
         r_ss_prev   <= w_ss;
         r_sclk_prev <= w_sclk;
         r_strobe    <= '0;
         r_start     <= 1'b0;
         r_load      <= |r_strobe;

         if (w_ss)           r_active <= 1'b0;
         else if (w_ss_fall) r_active <= 1'b1;

         // ss_n high has priority over a coincident 8th SCLK rise.
         if (w_ss || w_ss_fall) begin
            r_bit_cnt <= 3'd0;
            r_tgt_vld <= 1'b0;
         end else if (w_bit_rx) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
               if (r_phase == PH_ID) begin
                  r_tgt_vld <= w_id_ok;
                  r_tgt     <= TW'(w_byte - 8'd1);
               end else if (r_tgt_vld) begin
                  r_strobe[r_tgt] <= 1'b1;
                  r_start         <= (r_phase == PH_CMD);
                  r_data          <= w_byte;
               end
            end
         end

         // The SCLK fall that ends a byte (counter back at 0) must not shift,
         // otherwise the freshly loaded reply would lose its MSB.
         if (w_ss || w_ss_fall)
            r_miso_sr <= 8'd0;
         else if (r_load && r_tgt_vld)
            r_miso_sr <= data_in[{r_tgt, 3'b000} +: 8];
         else if (w_live && w_sclk_fall && (r_bit_cnt != 3'd0))
            r_miso_sr <= {r_miso_sr[6:0], 1'b0};
      end
   end

   assign spi_miso    = w_live & r_miso_sr[7];
   assign data_strobe = r_strobe;
   assign data_start  = r_start;
   assign data_out    = r_data;

endmodule

// File: tb/tb_mcu_spi_target.sv
// Self-checking bench for mcu_spi_target: an MCU driver, a consumer model and
// a frame-level reference that predicts strobes, data and MISO bytes.
module tb_mcu_spi_target;
   localparam int NT = 4;

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic            ss_n, sclk, mosi, miso;
   logic [NT-1:0]   strobe;
   logic            start;
   logic [7:0]      dout;
   logic [8*NT-1:0] din;

   mcu_spi_target #(.NTARGET(NT), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .spi_ss_n    (ss_n),
      .spi_sclk    (sclk),
      .spi_mosi    (mosi),
      .spi_miso    (miso),
      .data_strobe (strobe),
      .data_start  (start),
      .data_out    (dout),
      .data_in     (din)
   );

   int checks = 0;
   int errors = 0;

   // scoreboard: expected strobe events {mask, start, data}
   logic [12:0] exp_q[$];
   logic [7:0]  cons_q[$];
   logic [12:0] ev;
   logic [7:0]  model_dout;
   logic [NT-1:0] prev_strobe;
   int strobe_cnt[NT] = '{default: 0};
   int snap[NT];
   int ss_hi_cnt = 0;

   logic [7:0] fb[32];
   logic [7:0] rep[32];
   logic [7:0] got_miso[32];
   int flen;
   int hmin = 4;
   int hmax = 7;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // consumer model: registers its next reply one cycle after its strobe
   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NT; k++) din[8*k +: 8] <= 8'($urandom);
      end else begin
         for (int k = 0; k < NT; k++) begin
            if (strobe[k]) begin
               if (cons_q.size() != 0) din[8*k +: 8] <= cons_q.pop_front();
               else                    din[8*k +: 8] <= 8'hEE;
            end
         end
      end
   end

   // compare process: every cycle, away from the active edge
   initial begin
      model_dout  = 8'd0;
      prev_strobe = '0;
      forever begin
         @(negedge clk);
         if (ss_n) ss_hi_cnt++;
         else      ss_hi_cnt = 0;
         if (reset) begin
            model_dout  = 8'd0;
            prev_strobe = '0;
         end else begin
            if (strobe != '0) begin
               if (exp_q.size() == 0) begin
                  check("strobe_unexpected", 32'(strobe), 32'd0);
               end else begin
                  ev = exp_q.pop_front();
                  check("strobe_mask", 32'(strobe), 32'(ev[12:9]));
                  check("strobe_start", 32'(start), 32'(ev[8]));
                  check("strobe_data", 32'(dout), 32'(ev[7:0]));
                  model_dout = ev[7:0];
               end
               check("strobe_width", 32'(prev_strobe), 32'd0);
               for (int k = 0; k < NT; k++) if (strobe[k]) strobe_cnt[k]++;
            end else begin
               check("start_idle", 32'(start), 32'd0);
               check("data_hold", 32'(dout), 32'(model_dout));
            end
            prev_strobe = strobe;
            if (ss_hi_cnt > 4) check("miso_idle", 32'(miso), 32'd0);
         end
      end
   end

   // driver: one byte (or its first nbits) in SPI mode 0, MSB first
   task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] rx);
      rx = 8'd0;
      for (int i = 0; i < nbits; i++) begin
         mosi = b[7-i];
         repeat ($urandom_range(hmin, hmax)) @(negedge clk);
         rx = {rx[6:0], miso};
         sclk = 1'b1;
         repeat ($urandom_range(hmin, hmax)) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   // frame-level reference + stimulus; trunc = bits sent of the last byte
   task automatic run_frame(input int trunc);
      logic [7:0] rx;
      logic tv;
      int t, nb;
      tv = (fb[0] >= 1) && (fb[0] <= NT);
      t  = int'(fb[0]) - 1;
      for (int i = 1; i < flen; i++) begin
         if (tv && ((i < flen - 1) || (trunc == 8))) begin
            exp_q.push_back({4'(1 << t), (i == 1), fb[i]});
            cons_q.push_back(rep[i]);
         end
      end
      ss_n = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < flen; i++) begin
         nb = (i == flen - 1) ? trunc : 8;
         send_byte(fb[i], nb, rx);
         got_miso[i] = rx;
         if (nb == 8) check("miso_byte", 32'(rx), (tv && i >= 2) ? 32'(rep[i-1]) : 32'd0);
      end
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic take_snap();
      for (int k = 0; k < NT; k++) snap[k] = strobe_cnt[k];
   endtask

   task automatic chk_counts(input int e0, input int e1, input int e2, input int e3);
      int e[NT];
      e = '{e0, e1, e2, e3};
      for (int k = 0; k < NT; k++)
         check($sformatf("strobe_count_p%0d", k), 32'(strobe_cnt[k] - snap[k]), 32'(e[k]));
   endtask

   task automatic rand_fill(input int from, input int to);
      for (int i = from; i < to; i++) begin
         fb[i]  = 8'($urandom);
         rep[i] = 8'($urandom);
      end
   endtask

   initial begin
      logic [7:0] rx;
      int trunc;
      reset = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_miso", 32'(miso), 32'd0);
      check("reset_strobe", 32'(strobe), 32'd0);
      check("reset_start", 32'(start), 32'd0);
      check("reset_dout", 32'(dout), 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // target 1 with fixed replies
      take_snap();
      flen = 5;
      fb[0] = 8'h01; fb[1] = 8'h00; fb[2] = 8'hAA; fb[3] = 8'hAA; fb[4] = 8'hAA;
      rep[1] = 8'h5C; rep[2] = 8'h42; rep[3] = 8'h02; rep[4] = 8'h77;
      run_frame(8);
      check("t1_miso0", 32'(got_miso[0]), 32'h00);
      check("t1_miso1", 32'(got_miso[1]), 32'h00);
      check("t1_miso2", 32'(got_miso[2]), 32'h5C);
      check("t1_miso3", 32'(got_miso[3]), 32'h42);
      check("t1_miso4", 32'(got_miso[4]), 32'h02);
      chk_counts(4, 0, 0, 0);

      // target 3
      take_snap();
      flen = 4;
      fb[0] = 8'h03; fb[1] = 8'h04; fb[2] = 8'h53; fb[3] = 8'h02;
      rand_fill(16, 16);
      rep[1] = 8'h91; rep[2] = 8'h3E; rep[3] = 8'hC7;
      run_frame(8);
      check("t2_miso2", 32'(got_miso[2]), 32'h91);
      check("t2_miso3", 32'(got_miso[3]), 32'h3E);
      chk_counts(0, 0, 3, 0);

      // unknown ids 0x07 and 0x00
      take_snap();
      flen = 6; rand_fill(1, 6); fb[0] = 8'h07;
      run_frame(8);
      flen = 3; rand_fill(1, 3); fb[0] = 8'h00;
      run_frame(8);
      chk_counts(0, 0, 0, 0);

      // ss_n rises after 5 bits of byte 2, then a clean frame
      take_snap();
      flen = 3; fb[0] = 8'h01; fb[1] = 8'h11; fb[2] = 8'h22; rep[1] = 8'hA5;
      run_frame(5);
      chk_counts(1, 0, 0, 0);
      take_snap();
      flen = 3; fb[0] = 8'h01; fb[1] = 8'h01; fb[2] = 8'h03;
      rep[1] = 8'h6B; rep[2] = 8'hD2;
      run_frame(8);
      check("t4_miso2", 32'(got_miso[2]), 32'h6B);
      chk_counts(2, 0, 0, 0);

      // 16 bytes at minimum SCLK high/low time
      take_snap();
      hmin = 4; hmax = 4;
      flen = 16; rand_fill(1, 16); fb[0] = 8'h02;
      run_frame(8);
      hmin = 4; hmax = 7;
      chk_counts(0, 15, 0, 0);

      // asynchronous reset in the middle of byte 1
      ss_n = 1'b0;
      repeat (5) @(negedge clk);
      send_byte(8'h01, 8, rx);
      send_byte(8'h9A, 4, rx);
      sclk = 1'b1;
      #3 reset = 1'b1;
      #1;
      check("rst_mid_miso", 32'(miso), 32'd0);
      check("rst_mid_strobe", 32'(strobe), 32'd0);
      check("rst_mid_start", 32'(start), 32'd0);
      check("rst_mid_dout", 32'(dout), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0; ss_n = 1'b1; sclk = 1'b0;
      repeat (10) @(negedge clk);
      take_snap();
      flen = 4; rand_fill(1, 4); fb[0] = 8'h04;
      run_frame(8);
      chk_counts(0, 0, 0, 3);

      // randomized frames
      for (int f = 0; f < 12; f++) begin
         flen = $urandom_range(1, 8);
         rand_fill(0, flen);
         fb[0] = 8'($urandom_range(0, 5));
         trunc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
         run_frame(trunc);
      end

      repeat (20) @(negedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("cons_q_drained", 32'(cons_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // final report if the run stalls
   initial begin
      #800000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
